// File: rtl/led_actor_pkg.sv
// Shared constants and state encoding for the LED strip encoder.
package led_actor_pkg;

    localparam int PIXEL_WIDTH      = 24;
    localparam int SEGMENTS_PER_BIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

endpackage

// File: rtl/led_bit_serializer.sv
// Pixel shift register with bit and segment down-counters; emits the segment level
// for the current bit (1 -> H,H,H,L ; 0 -> H,L,L,L), MSB first.
module led_bit_serializer
    import led_actor_pkg::*;
(
    input  logic                   clock_12mhz,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [PIXEL_WIDTH-1:0] i_data,
    input  logic                   i_advance,
    output logic                   o_level,
    output logic                   o_last_seg
);

    localparam int BIT_CNT_W = $clog2(PIXEL_WIDTH);
    localparam int SEG_CNT_W = $clog2(SEGMENTS_PER_BIT);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(PIXEL_WIDTH - 1);
    localparam logic [SEG_CNT_W-1:0] SEG_LAST = SEG_CNT_W'(SEGMENTS_PER_BIT - 1);

    logic [PIXEL_WIDTH-1:0] r_shift;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [SEG_CNT_W-1:0]   r_seg_cnt;

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_seg_cnt <= '0;
        end else if (i_load) begin
            r_shift   <= i_data;
            r_bit_cnt <= BIT_LAST;
            r_seg_cnt <= SEG_LAST;
        end else if (i_advance) begin
            if (r_seg_cnt == '0) begin
                r_seg_cnt <= SEG_LAST;
                r_shift   <= {r_shift[PIXEL_WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
            end else begin
                r_seg_cnt <= r_seg_cnt - SEG_CNT_W'(1);
            end
        end
    end

    // Segment counter counts down: SEG_LAST is the leading high segment, 0 the trailing low one.
    assign o_level    = (r_seg_cnt == SEG_LAST) | ((r_seg_cnt != '0) & r_shift[PIXEL_WIDTH-1]);
    assign o_last_seg = (r_bit_cnt == '0) & (r_seg_cnt == '0);

endmodule

// File: rtl/led_strip_encoder.sv
// Frame sequencer for a single-wire GRB LED strip: pixel handshake, double buffering,
// segment-rate serialisation via led_bit_serializer, and the trailing latch low period.
//   state | meaning
//   IDLE  | line low, waiting for frame_start
//   PRIME | collecting the first pixel into the shift register
//   SEND  | streaming segments, refilling from the next register
//   LATCH | line held low for LATCH_TICKS segment ticks
module led_strip_encoder
    import led_actor_pkg::*;
#(
    parameter int NUM_LEDS    = 150,
    parameter int LATCH_TICKS = 160
)(
    input  logic                   clock_12mhz,
    input  logic                   reset_n,
    input  logic                   segment_tick,
    input  logic                   frame_start,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    output logic [7:0]             pixel_index,
    output logic                   led_data,
    output logic                   busy,
    output logic                   underrun
);

    localparam logic [7:0]  LEDS       = 8'(NUM_LEDS);
    localparam logic [7:0]  LAST_INDEX = 8'(NUM_LEDS - 1);
    localparam logic [15:0] LATCH_LOAD = 16'(LATCH_TICKS);

    state_t                 r_state;
    logic [PIXEL_WIDTH-1:0] r_next;
    logic                   r_next_full;
    logic                   r_primed;
    logic [7:0]             r_accept_left;
    logic [7:0]             r_send_left;
    logic [7:0]             r_pixel_index;
    logic [15:0]            r_latch_left;
    logic                   r_led_data;
    logic                   r_underrun;

    logic                   w_xfer;
    logic                   w_boundary;
    logic                   w_last_pixel;
    logic                   w_load_prime;
    logic                   w_load_boundary;
    logic                   w_load;
    logic [PIXEL_WIDTH-1:0] w_load_data;
    logic                   w_advance;
    logic                   w_level;
    logic                   w_last_seg;

    assign pixel_ready = ((r_state == PRIME) || (r_state == SEND)) && !r_next_full
                         && (r_accept_left != 8'd0);
    assign w_xfer          = pixel_valid & pixel_ready;
    assign w_boundary      = (r_state == SEND) & segment_tick & w_last_seg;
    assign w_last_pixel    = (r_send_left == 8'd1);
    assign w_load_prime    = (r_state == PRIME) & w_xfer & ~r_primed;
    // A transfer landing on the boundary tick goes straight into the shift register.
    assign w_load_boundary = w_boundary & ~w_last_pixel & (r_next_full | w_xfer);
    assign w_load          = w_load_prime | w_load_boundary;
    assign w_load_data     = r_next_full ? r_next : pixel_data;
    assign w_advance       = (r_state == SEND) & segment_tick & ~w_last_seg;

    led_bit_serializer u_serializer (
        .clock_12mhz (clock_12mhz),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_data      (w_load_data),
        .i_advance   (w_advance),
        .o_level     (w_level),
        .o_last_seg  (w_last_seg)
    );

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_next        <= '0;
            r_next_full   <= 1'b0;
            r_primed      <= 1'b0;
            r_accept_left <= '0;
            r_send_left   <= '0;
            r_pixel_index <= '0;
            r_latch_left  <= '0;
            r_led_data    <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_xfer) begin
                r_accept_left <= r_accept_left - 8'd1;
                if (r_pixel_index != LAST_INDEX)
                    r_pixel_index <= r_pixel_index + 8'd1;
                if (!w_load) begin
                    r_next      <= pixel_data;
                    r_next_full <= 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_state       <= PRIME;
                        r_pixel_index <= '0;
                        r_accept_left <= LEDS;
                        r_send_left   <= LEDS;
                        r_primed      <= 1'b0;
                        r_next_full   <= 1'b0;
                    end
                end
                PRIME: begin
                    if (w_load_prime)
                        r_primed <= 1'b1;
                    if (segment_tick && r_primed)
                        r_state <= SEND;
                end
                SEND: begin
                    if (segment_tick) begin
                        r_led_data <= w_level;
                        if (w_last_seg) begin
                            r_send_left <= r_send_left - 8'd1;
                            if (w_last_pixel) begin
                                r_state      <= LATCH;
                                r_latch_left <= LATCH_LOAD;
                            end else if (r_next_full) begin
                                r_next_full <= 1'b0;
                            end else if (!w_xfer) begin
                                r_underrun   <= 1'b1;
                                r_led_data   <= 1'b0;
                                r_state      <= LATCH;
                                r_latch_left <= LATCH_LOAD;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (segment_tick) begin
                        r_led_data <= 1'b0;
                        if (r_latch_left <= 16'd1)
                            r_state <= IDLE;
                        else
                            r_latch_left <= r_latch_left - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pixel_index = r_pixel_index;
    assign led_data    = r_led_data;
    assign busy        = (r_state != IDLE);
    assign underrun    = r_underrun;

endmodule
